// File: rtl/q2_sequencer.sv
// q2 control sequencer: fetch/decode/execute micro-sequencing of the bit-slice
// strobes, front-panel run/step/deposit, and the memory handshake with timeout.
module q2_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned SETTLE  = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] op,
  input  logic       xzero,
  input  logic       run,
  input  logic       step,
  input  logic       dep_req,
  input  logic       mem_rdy,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       rdp,
  output logic       rdx,
  output logic       rda,
  output logic       dep,
  output logic       wra,
  output logic       wrx,
  output logic       incp_clk,
  output logic       nwrp,
  output logic       xin_zero,
  output logic       xin_shift,
  output logic       xin_p,
  output logic       xin_dbus,
  output logic       halted,
  output logic       err
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_LDX = 3'd2;
  localparam logic [2:0] OP_SHX = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_CLX = 3'd5;
  localparam logic [2:0] OP_SKZ = 3'd6;

  typedef enum logic [3:0] {
    IDLE, F_ADDR, F_WAIT, F_LATCH, F_INCP, DECODE, E_ADDR, E_WAIT, E_DO,
    DEP_ADDR, DEP_WAIT, DEP_INCP, HALT
  } state_e;

  typedef struct packed {
    logic mem_rd, mem_wr, ir_load, rdp, rdx, rda, dep, wra, wrx, incp_clk;
    logic nwrp, xin_zero, xin_shift, xin_p, xin_dbus, halted;
  } out_t;

  localparam out_t OUT_RST = '{nwrp: 1'b1, halted: 1'b1, default: 1'b0};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  out_t          out_q, out_d;
  logic          exec_done;

  // Next-state: cnt_q doubles as settle counter, wait counter and execute phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    err_d     = err_q;
    exec_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (dep_req) begin
          state_d = DEP_ADDR;
          cnt_d   = '0;
        end else if (run || step) begin
          state_d = F_ADDR;
          cnt_d   = '0;
          step_d  = step;
        end
      end
      F_ADDR, E_ADDR, DEP_ADDR: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == F_ADDR) ? F_WAIT :
                    (state_q == E_ADDR) ? E_WAIT : DEP_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      F_WAIT, E_WAIT, DEP_WAIT: begin
        if (mem_rdy) begin
          cnt_d = '0;
          if (state_q == F_WAIT)        state_d = F_LATCH;
          else if (state_q == DEP_WAIT) state_d = DEP_INCP;
          else if (op == OP_STA)        exec_done = 1'b1;
          else                          state_d = E_DO;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      F_LATCH:  state_d = F_INCP;
      F_INCP:   state_d = DECODE;
      DECODE: begin
        cnt_d = '0;
        case (op)
          OP_LDA, OP_STA, OP_LDX: state_d = E_ADDR;
          OP_SHX, OP_JMP, OP_CLX, OP_SKZ: state_d = E_DO;
          default: state_d = HALT;
        endcase
      end
      E_DO: begin
        // LDX/SHX/JMP/CLX need a second cycle: select first, then the pulse.
        if (cnt_q == ((op inside {OP_LDX, OP_SHX, OP_JMP, OP_CLX}) ? CW'(1) : CW'(0)))
          exec_done = 1'b1;
        else
          cnt_d = cnt_q + CW'(1);
      end
      DEP_INCP: state_d = IDLE;
      default:  state_d = HALT;
    endcase
    if (exec_done) begin
      cnt_d = '0;
      if (step_q || !run) begin
        state_d = IDLE;
        step_d  = 1'b0;
      end else begin
        state_d = F_ADDR;
      end
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    out_d      = '0;
    out_d.nwrp = 1'b1;
    case (state_d)
      IDLE, HALT: out_d.halted = 1'b1;
      F_ADDR:     out_d.rdp = 1'b1;
      F_WAIT:     begin out_d.rdp = 1'b1; out_d.mem_rd = 1'b1; end
      F_LATCH:    begin out_d.rdp = 1'b1; out_d.ir_load = 1'b1; end
      F_INCP:     out_d.incp_clk = 1'b1;
      E_ADDR, E_WAIT: begin
        case (op)
          OP_LDA:  out_d.rdx = 1'b1;
          OP_STA:  begin out_d.rdx = 1'b1; out_d.rda = 1'b1; end
          default: begin out_d.rdp = 1'b1; out_d.xin_dbus = 1'b1; end
        endcase
        if (state_d == E_WAIT) begin
          out_d.mem_wr = (op == OP_STA);
          out_d.mem_rd = (op != OP_STA);
        end
      end
      E_DO: begin
        case (op)
          OP_LDA: begin out_d.rdx = 1'b1; out_d.wra = 1'b1; end
          OP_LDX: begin
            if (cnt_d == '0) begin
              out_d.rdp      = 1'b1;
              out_d.xin_dbus = 1'b1;
              out_d.wrx      = 1'b1;
            end else begin
              out_d.incp_clk = 1'b1;
            end
          end
          OP_SHX: begin out_d.xin_shift = 1'b1; out_d.wrx = (cnt_d != '0); end
          OP_JMP: begin out_d.rdx = 1'b1; out_d.nwrp = (cnt_d == '0); end
          OP_CLX: begin out_d.xin_zero = 1'b1; out_d.wrx = (cnt_d != '0); end
          OP_SKZ: out_d.incp_clk = xzero;
          default: ;
        endcase
      end
      DEP_ADDR: begin out_d.rdp = 1'b1; out_d.dep = 1'b1; end
      DEP_WAIT: begin out_d.rdp = 1'b1; out_d.dep = 1'b1; out_d.mem_wr = 1'b1; end
      DEP_INCP: out_d.incp_clk = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign mem_rd    = out_q.mem_rd;
  assign mem_wr    = out_q.mem_wr;
  assign ir_load   = out_q.ir_load;
  assign rdp       = out_q.rdp;
  assign rdx       = out_q.rdx;
  assign rda       = out_q.rda;
  assign dep       = out_q.dep;
  assign wra       = out_q.wra;
  assign wrx       = out_q.wrx;
  assign incp_clk  = out_q.incp_clk;
  assign nwrp      = out_q.nwrp;
  assign xin_zero  = out_q.xin_zero;
  assign xin_shift = out_q.xin_shift;
  assign xin_p     = out_q.xin_p;
  assign xin_dbus  = out_q.xin_dbus;
  assign halted    = out_q.halted;
  assign err       = err_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// Bench for q2_sequencer: per-cycle {inputs, expected outputs} records, built
// from the instruction-level timing rules and applied one record per clock.
module tb_q2_sequencer;
  localparam int unsigned SETTLE  = 1;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic nrst, xzero, run, step, dep_req, mem_rdy;
  logic [2:0] op;
  logic mem_rd, mem_wr, ir_load, rdp, rdx, rda, dep, wra, wrx, incp_clk;
  logic nwrp, xin_zero, xin_shift, xin_p, xin_dbus, halted, err;

  always #5 clk = ~clk;

  q2_sequencer #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .nrst(nrst), .op(op), .xzero(xzero), .run(run), .step(step),
    .dep_req(dep_req), .mem_rdy(mem_rdy), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_load(ir_load), .rdp(rdp), .rdx(rdx), .rda(rda), .dep(dep), .wra(wra),
    .wrx(wrx), .incp_clk(incp_clk), .nwrp(nwrp), .xin_zero(xin_zero),
    .xin_shift(xin_shift), .xin_p(xin_p), .xin_dbus(xin_dbus),
    .halted(halted), .err(err)
  );

  // Output bit masks; the NWRP bit means "nwrp asserted (low)" while building.
  localparam logic [16:0] MRD = 17'h10000, MWR = 17'h08000, IRL = 17'h04000;
  localparam logic [16:0] RDP = 17'h02000, RDX = 17'h01000, RDA = 17'h00800;
  localparam logic [16:0] DEP = 17'h00400, WRA = 17'h00200, WRX = 17'h00100;
  localparam logic [16:0] INC = 17'h00080, NWP = 17'h00040, XZS = 17'h00020;
  localparam logic [16:0] XSH = 17'h00010, XDB = 17'h00004;
  localparam logic [16:0] HLT = 17'h00002, ERR = 17'h00001;
  localparam int K_FREE = 0, K_BUSY = 1, K_RDY = 2, K_HALT = 3;

  typedef struct packed {
    logic [2:0]  op;
    logic        xzero, run, step, dep_req, mem_rdy;
    logic [16:0] exp;
  } vec_t;

  logic [16:0] act;
  assign act = {mem_rd, mem_wr, ir_load, rdp, rdx, rda, dep, wra, wrx, incp_clk,
                nwrp, xin_zero, xin_shift, xin_p, xin_dbus, halted, err};

  int   checks = 0, failures = 0, vidx = 0;
  vec_t vq[$];
  vec_t tbl[11];
  logic [2:0] g_op;
  logic g_xz, g_run;

  task automatic check(input string name, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%05h want=%05h", name, vidx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic xz, r, s, d, rdy,
                              input logic [16:0] outs);
    vec_t v;
    v.op = o; v.xzero = xz; v.run = r; v.step = s; v.dep_req = d; v.mem_rdy = rdy;
    v.exp = outs ^ NWP;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    @(posedge clk); #1;
    op = v.op; xzero = v.xzero; run = v.run; step = v.step;
    dep_req = v.dep_req; mem_rdy = v.mem_rdy;
    @(negedge clk);
    check(name, v.exp);
    vidx++;
  endtask

  task automatic flush(input string name);
    while (vq.size() > 0) apply(name, vq.pop_front());
  endtask

  // Called away from the rising edge; checks the asynchronous reset response.
  task automatic do_reset();
    nrst = 1'b0; run = 1'b0; step = 1'b0; dep_req = 1'b0; mem_rdy = 1'b0;
    #1 check("reset_async", HLT | NWP);
    @(negedge clk);
    check("reset_hold", HLT | NWP);
    nrst = 1'b1;
  endtask

  // Non-idle cycle; step/dep_req (and mem_rdy outside waits) carry random noise.
  task automatic add(input logic [16:0] o, input int kind);
    vec_t v;
    v = mk(g_op, g_xz, g_run, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), 1'b0, o);
    if (kind == K_RDY) v.mem_rdy = 1'b1;
    else if (kind != K_BUSY) v.mem_rdy = ($urandom_range(0, 3) == 0);
    if (kind == K_HALT) v.run = 1'(($urandom_range(0, 1)));
    vq.push_back(v);
  endtask

  task automatic idle_rec(input logic s, input logic d);
    vq.push_back(mk(g_op, g_xz, g_run, s, d, 1'($urandom_range(0, 1)), HLT));
  endtask

  task automatic wait_recs(input logic [16:0] o, input int n);
    for (int i = 0; i < n - 1; i++) add(o, K_BUSY);
    add(o, K_RDY);
  endtask

  // Fetch; the new opcode appears on the IR when ir_load fires.
  task automatic fetch(input logic [2:0] nop, input int fw, input logic drop);
    repeat (SETTLE) add(RDP, K_FREE);
    wait_recs(RDP | MRD, fw);
    g_op = nop;
    if (drop) g_run = 1'b0;
    add(RDP | IRL, K_FREE);
    add(INC, K_FREE);
    add('0, K_FREE);
  endtask

  task automatic exec(input int ew);
    case (g_op)
      3'd0: begin repeat (SETTLE) add(RDX, K_FREE); wait_recs(RDX | MRD, ew);
                  add(RDX | WRA, K_FREE); end
      3'd1: begin repeat (SETTLE) add(RDX | RDA, K_FREE);
                  wait_recs(RDX | RDA | MWR, ew); end
      3'd2: begin repeat (SETTLE) add(RDP | XDB, K_FREE);
                  wait_recs(RDP | XDB | MRD, ew);
                  add(RDP | XDB | WRX, K_FREE); add(INC, K_FREE); end
      3'd3: begin add(XSH, K_FREE); add(XSH | WRX, K_FREE); end
      3'd4: begin add(RDX, K_FREE); add(RDX | NWP, K_FREE); end
      3'd5: begin add(XZS, K_FREE); add(XZS | WRX, K_FREE); end
      3'd6: add(g_xz ? INC : '0, K_FREE);
      default: ;
    endcase
  endtask

  task automatic instr(input logic [2:0] nop, input int fw, input int ew,
                       input logic drop);
    fetch(nop, fw, drop);
    exec(ew);
  endtask

  task automatic deposit(input int n);
    repeat (SETTLE) add(RDP | DEP, K_FREE);
    wait_recs(RDP | DEP | MWR, n);
    add(INC, K_FREE);
  endtask

  initial begin
    int   kind, k;
    logic both;
    nrst = 1'b1; op = '0; xzero = 1'b0; run = 1'b0; step = 1'b0;
    dep_req = 1'b0; mem_rdy = 1'b0;
    g_op = '0; g_xz = 1'b0; g_run = 1'b0;
    #2 do_reset();

    // Single-step LDA, memory ready in the second fetch-wait cycle.
    tbl[0]  = mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, HLT);
    tbl[1]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDP);
    tbl[2]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDP | MRD);
    tbl[3]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RDP | MRD);
    tbl[4]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDP | IRL);
    tbl[5]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, INC);
    tbl[6]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tbl[7]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDX);
    tbl[8]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RDX | MRD);
    tbl[9]  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDX | WRA);
    tbl[10] = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HLT);
    for (int i = 0; i < 11; i++) apply("lda_step", tbl[i]);

    // Reset in the middle of a fetch wait, then a clean step.
    idle_rec(1'b1, 1'b0); add(RDP, K_FREE); add(RDP | MRD, K_BUSY);
    flush("rst_pre");
    do_reset();
    idle_rec(1'b1, 1'b0); instr(3'd0, 1, 1, 1'b0); idle_rec(1'b0, 1'b0);
    flush("rst_post");

    // Free run LDX, SHX, JMP, then STA with run dropped mid-instruction.
    g_run = 1'b1; idle_rec(1'b0, 1'b0);
    instr(3'd2, 1, 2, 1'b0); instr(3'd3, 2, 1, 1'b0);
    instr(3'd4, 1, 1, 1'b0); instr(3'd1, 2, 3, 1'b1);
    idle_rec(1'b0, 1'b0);
    flush("run_seq");

    // SKZ taken vs not taken.
    g_xz = 1'b1; idle_rec(1'b1, 1'b0); instr(3'd6, 1, 1, 1'b0); idle_rec(1'b0, 1'b0);
    g_xz = 1'b0; idle_rec(1'b1, 1'b0); instr(3'd6, 1, 1, 1'b0); idle_rec(1'b0, 1'b0);
    flush("skz");

    // Deposit (wins over a simultaneous step), memory ready after 3 cycles.
    idle_rec(1'b1, 1'b1); deposit(3); idle_rec(1'b0, 1'b0);
    flush("deposit");

    // Randomized mix of steps, run bursts and deposits.
    repeat (30) begin
      kind = $urandom_range(0, 2);
      g_xz = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        both = 1'($urandom_range(0, 1));
        g_run = both;
        idle_rec(1'b1, 1'b0);
        instr(3'($urandom_range(0, 6)), $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
        g_run = 1'b0;
        idle_rec(1'b0, 1'b0);
      end else if (kind == 1) begin
        k = $urandom_range(1, 4);
        g_run = 1'b1;
        idle_rec(1'b0, 1'b0);
        for (int j = 0; j < k; j++) begin
          g_xz = 1'($urandom_range(0, 1));
          instr(3'($urandom_range(0, 6)), $urandom_range(1, 4), $urandom_range(1, 4),
                (j == k - 1));
        end
        idle_rec(1'b0, 1'b0);
      end else begin
        g_run = 1'b0;
        idle_rec(1'($urandom_range(0, 1)), 1'b1);
        deposit($urandom_range(1, 4));
        idle_rec(1'b0, 1'b0);
      end
      flush("random");
    end

    // HLT stops for good: run/step/dep_req ignored until reset.
    g_run = 1'b0;
    idle_rec(1'b1, 1'b0); fetch(3'd7, 1, 1'b0);
    repeat (4) add(HLT, K_HALT);
    flush("hlt");
    do_reset();

    // Memory never answers: abort after TIMEOUT wait cycles with err set.
    g_op = 3'd0;
    idle_rec(1'b1, 1'b0);
    repeat (SETTLE) add(RDP, K_FREE);
    repeat (TIMEOUT) add(RDP | MRD, K_BUSY);
    repeat (5) add(HLT | ERR, K_HALT);
    flush("timeout");
    do_reset();
    idle_rec(1'b1, 1'b0); instr(3'd5, 1, 1, 1'b0); idle_rec(1'b0, 1'b0);
    flush("post_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
- Control sequencer that sits directly upstream of the q2 bit-slice array. It drives every slice strobe and select (A/X/P load and read enables, X input mux, P increment/write, deposit) and the external memory handshake.
- It fetches an instruction from mem[P], latches it into the external instruction register, increments P, decodes the 3-bit opcode and runs the execute micro-sequence.
- It also services front-panel run/step/deposit requests while stopped.

Parameters:
- TIMEOUT, 15, maximum cycles spent waiting for mem_rdy before the block aborts to HALT with err set.
- SETTLE, 1, cycles that bus-read enables (rdp/rdx/rda/dep) are held before any write pulse or mem request (range 1..3).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- nrst  in  1  asynchronous active-low reset.
- op  in  3  opcode from the external instruction register.
- xzero  in  1  X register equals zero, from the slice array.
- run  in  1  level: free-running execution while high.
- step  in  1  one-cycle pulse: execute exactly one instruction from IDLE.
- dep_req  in  1  one-cycle pulse: deposit the switch word at mem[P], then P++ (IDLE only).
- mem_rdy  in  1  memory completes the current access.
- mem_rd, mem_wr  out  1  memory request levels, held until mem_rdy.
- ir_load  out  1  one-cycle pulse: latch dbus into the instruction register.
- rdp, rdx, rda, dep  out  1  bus drive enables, active-high levels.
- wra, wrx, incp_clk  out  1  register clocks to the slices, one-cycle high pulses.
- nwrp  out  1  active-low P parallel-load strobe.
- xin_zero, xin_shift, xin_p, xin_dbus  out  1  X input select; at most one high at a time.
- halted  out  1  high in IDLE and HALT.
- err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async): state = IDLE. All pulses, enables and mem_* = 0. nwrp = 1. err = 0. halted = 1.
- States: IDLE, F_ADDR, F_WAIT, F_LATCH, F_INCP, DECODE, E_ADDR, E_WAIT, E_DO, DEP_ADDR, DEP_WAIT, DEP_INCP, HALT.
- IDLE transitions, in priority order:
  - dep_req -> DEP_ADDR.
  - run or step -> F_ADDR. A step latches a one-shot flag.
- Fetch sequence:
  - F_ADDR: rdp=1 for SETTLE cycles, then -> F_WAIT.
  - F_WAIT: rdp=1, mem_rd=1. On mem_rdy -> F_LATCH.
  - F_LATCH: rdp=1, ir_load pulse.
  - F_INCP: incp_clk pulse.
  - DECODE: one cycle, no outputs.
- Execute, by op:
  - 0 LDA: A<=mem[X]. E_ADDR asserts rdx; E_WAIT asserts rdx and mem_rd; E_DO asserts wra pulse with rdx held.
  - 1 STA: mem[X]<=A. rdx and rda held through E_ADDR and E_WAIT; mem_wr in E_WAIT.
  - 2 LDX: X<=mem[P], then P++. rdp and xin_dbus held; mem_rd; wrx pulse in E_DO; then incp_clk pulse in the following cycle.
  - 3 SHX: xin_shift=1 one cycle, then wrx pulse (2 cycles).
  - 4 JMP: nwrp=0 for exactly one cycle (P<=X).
  - 5 CLX: xin_zero=1, then wrx pulse.
  - 6 SKZ: if xzero, incp_clk pulse; else no operation. Duration is 1 cycle in both cases.
  - 7 HLT: -> HALT.
- After execute:
  - step flag set, or run low -> IDLE (flag cleared).
  - otherwise -> F_ADDR.
- Select/pulse timing: every select or enable is high at least one cycle before and during its write pulse, and drops the cycle after. A pulse never coincides with a select change.
- Deposit sequence:
  - DEP_ADDR: rdp and dep high for SETTLE cycles.
  - DEP_WAIT: rdp, dep, mem_wr held until mem_rdy.
  - DEP_INCP: incp_clk pulse, then IDLE.
- Waits: the wait counter clears on entering any *_WAIT state. If it reaches TIMEOUT without mem_rdy: mem_* drop, err=1, -> HALT.
- HALT: halted=1. Leaves only via nrst; run/step/dep_req are ignored.
- run dropping mid-instruction does not abort; the current instruction completes.
- mem_rdy outside a WAIT state is ignored.
- step/dep_req arriving outside IDLE are dropped, not queued.

Test Plan:
- Reset mid-F_WAIT (nrst low) -> next cycle all outputs idle, nwrp=1, halted=1, err=0; release then step -> fetch restarts at F_ADDR.
- step, op=0, mem_rdy in the 2nd wait cycle -> rdp 1 cycle, mem_rd 2, ir_load, incp_clk, DECODE, rdx, wra pulse; back in IDLE at cycle 10 (SETTLE=1).
- run=1, op stream 2,3,4 -> LDX gives wrx followed by incp_clk; SHX gives xin_shift one cycle before wrx; JMP gives nwrp low exactly 1 cycle; fetch continues.
- op=6 with xzero=1, then with xzero=0 -> one incp_clk pulse vs. none; identical instruction length.
- dep_req in IDLE, mem_rdy after 3 cycles -> dep and rdp high throughout, mem_wr 3 cycles, incp_clk, return IDLE; dep_req during run -> ignored.
- mem_rdy never asserted (TIMEOUT=15) -> after 15 wait cycles mem_rd=0, err=1, HALT; step ignored until nrst.
